chunk_loader: RTL

Parametrised session-material loader for the cipher core. On `start` it fills three register fields (key, nonce, counter) word by word. Each field is sourced either from the external chunk stream (`chunk_request`/`chunk_valid` handshake with typed requests) or from the TRNG (`trng_request`/`trng_ready`). It replaces the fixed-width loading logic inside the top level, and adds configurable field depths, type checking, a wait timeout and a zero-counter mode. It sits between the host/TRNG pins and the core's key/nonce/counter inputs.

---
 rtl/chunk_loader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/chunk_loader.sv
// chunk_loader: fills key, nonce and counter registers word by word from
// the host chunk stream or the TRNG.
// Ports: clk/rst (sync, active high); start plus per-field source selects;
//   chunk stream (chunk, chunk_valid, chunk_type / chunk_request,
//   request_type, chunk_index); TRNG (trng_data, trng_ready / trng_request);
//   key_out, nonce_out, ctr_out; status busy, done, valid, err, err_code.
module chunk_loader #(
  parameter int WORD_W         = 32,
  parameter int KEY_WORDS      = 8,
  parameter int NONCE_WORDS    = 3,
  parameter int CTR_WORDS      = 1,
  parameter int IDX_W          = 5,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CTR_FROM_TRNG  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          use_streamed_key,
  input  logic                          use_streamed_nonce,
  input  logic                          use_streamed_counter,
  input  logic [WORD_W-1:0]             chunk,
  input  logic                          chunk_valid,
  input  logic [1:0]                    chunk_type,
  output logic                          chunk_request,
  output logic [1:0]                    request_type,
  output logic [IDX_W-1:0]              chunk_index,
  input  logic [WORD_W-1:0]             trng_data,
  input  logic                          trng_ready,
  output logic                          trng_request,
  output logic [KEY_WORDS*WORD_W-1:0]   key_out,
  output logic [NONCE_WORDS*WORD_W-1:0] nonce_out,
  output logic [CTR_WORDS*WORD_W-1:0]   ctr_out,
  output logic                          busy,
  output logic                          done,
  output logic                          valid,
  output logic                          err,
  output logic [1:0]                    err_code
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ?
                      $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_KEY, S_NONCE, S_CTR, S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [2:0]        src_sel;
  logic [TW-1:0]     timer;
  logic [1:0]        fld;
  logic              streamed;
  logic [IDX_W-1:0]  last_idx;
  logic              accept;
  logic              mismatch;
  logic              tmo;
  logic              last;
  logic              skip_ctr;
  logic [WORD_W-1:0] word;

  always_comb begin
    state_nx = state;
    fld      = 2'd0;
    streamed = 1'b0;
    last_idx = '0;
    case (state)
      S_KEY: begin
        fld      = 2'd0;
        streamed = src_sel[0];
        last_idx = IDX_W'(KEY_WORDS - 1);
      end
      S_NONCE: begin
        fld      = 2'd1;
        streamed = src_sel[1];
        last_idx = IDX_W'(NONCE_WORDS - 1);
      end
      S_CTR: begin
        fld      = 2'd2;
        streamed = src_sel[2];
        last_idx = IDX_W'(CTR_WORDS - 1);
      end
      default: ;
    endcase

    busy          = (state == S_KEY) || (state == S_NONCE) ||
                    (state == S_CTR);
    done          = (state == S_DONE);
    chunk_request = busy && streamed;
    trng_request  = busy && !streamed;
    request_type  = fld;

    mismatch = chunk_request && chunk_valid && (chunk_type != fld);
    accept   = chunk_request ? (chunk_valid && chunk_type == fld)
                             : (trng_request && trng_ready);
    tmo      = (TIMEOUT_CYCLES != 0) && busy && !accept && !mismatch &&
               (timer == TW'(TIMEOUT_CYCLES - 1));
    last     = (chunk_index == last_idx);
    word     = streamed ? chunk : trng_data;
    // Internal counter source of all-zero needs no load cycles at all.
    skip_ctr = !src_sel[2] && (CTR_FROM_TRNG == 0);

    case (state)
      S_IDLE:
        if (start) state_nx = S_KEY;
      S_KEY:
        if (mismatch || tmo)   state_nx = S_DONE;
        else if (accept && last) state_nx = S_NONCE;
      S_NONCE:
        if (mismatch || tmo)   state_nx = S_DONE;
        else if (accept && last)
          state_nx = skip_ctr ? S_DONE : S_CTR;
      S_CTR:
        if (mismatch || tmo || (accept && last)) state_nx = S_DONE;
      S_DONE:
        state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      src_sel     <= '0;
      chunk_index <= '0;
      timer       <= '0;
      key_out     <= '0;
      nonce_out   <= '0;
      ctr_out     <= '0;
      valid       <= 1'b0;
      err         <= 1'b0;
      err_code    <= 2'b00;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        src_sel     <= {use_streamed_counter, use_streamed_nonce,
                        use_streamed_key};
        chunk_index <= '0;
        timer       <= '0;
        key_out     <= '0;
        nonce_out   <= '0;
        ctr_out     <= '0;
        valid       <= 1'b0;
        err         <= 1'b0;
        err_code    <= 2'b00;
      end else if (busy) begin
        unique case (1'b1)
          mismatch: begin
            err         <= 1'b1;
            err_code    <= 2'b01;
            chunk_index <= '0;
          end
          tmo: begin
            err         <= 1'b1;
            err_code    <= 2'b10;
            chunk_index <= '0;
          end
          accept: begin
            for (int i = 0; i < KEY_WORDS; i++)
              if (state == S_KEY && chunk_index == IDX_W'(i))
                key_out[i*WORD_W +: WORD_W] <= word;
            for (int i = 0; i < NONCE_WORDS; i++)
              if (state == S_NONCE && chunk_index == IDX_W'(i))
                nonce_out[i*WORD_W +: WORD_W] <= word;
            for (int i = 0; i < CTR_WORDS; i++)
              if (state == S_CTR && chunk_index == IDX_W'(i))
                ctr_out[i*WORD_W +: WORD_W] <= word;
            timer       <= '0;
            chunk_index <= last ? '0 : chunk_index + 1'b1;
            if (last && state_nx == S_DONE) valid <= 1'b1;
          end
          default:
            if (TIMEOUT_CYCLES != 0) timer <= timer + 1'b1;
        endcase
      end
    end
  end

endmodule
